// File: rtl/wb_master_bridge_pkg.sv
// Shared definitions for the Wishbone classic initiator bridge:
// state encoding, bus data width and timeout defaults.
package wb_master_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned WB_DW           = 8;
  localparam int unsigned DEFAULT_TIMEOUT = 16;

  // Bits needed to count 0..limit-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 32'd1) ? $clog2(limit) : 32'd1;
  endfunction

endpackage

// File: rtl/wb_master_bridge_if.sv
// CPU request side and Wishbone side of the bridge; the master modport is the
// bridge's view, the slave modport is the view of the core plus the responder.
interface wb_master_bridge_if
  import wb_master_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 24
);

  logic                  CPU_REQ;
  logic                  CPU_WE;
  logic [ADDR_WIDTH-1:0] CPU_ADDR;
  logic [WB_DW-1:0]      CPU_WDAT;
  logic                  CPU_RDY;
  logic                  CPU_DONE;
  logic                  CPU_ERR;
  logic [WB_DW-1:0]      CPU_RDAT;

  logic [ADDR_WIDTH-1:0] WB_ADRo;
  logic [WB_DW-1:0]      WB_DATo;
  logic [WB_DW-1:0]      WB_DATi;
  logic                  WB_WEo;
  logic                  WB_CYCo;
  logic                  WB_STBo;
  logic                  WB_ACKi;

  modport master (
    input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDAT, WB_DATi, WB_ACKi,
    output CPU_RDY, CPU_DONE, CPU_ERR, CPU_RDAT,
           WB_ADRo, WB_DATo, WB_WEo, WB_CYCo, WB_STBo
  );

  modport slave (
    output CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDAT, WB_DATi, WB_ACKi,
    input  CPU_RDY, CPU_DONE, CPU_ERR, CPU_RDAT,
           WB_ADRo, WB_DATo, WB_WEo, WB_CYCo, WB_STBo
  );

endinterface

// File: rtl/wb_master_bridge_timeout_cnt.sv
// Saturating up-counter with clear/enable; expire is high while the count sits
// at LIMIT-1. Shared by bus masters that must abandon unanswered cycles.
module wb_timeout_cnt #(
  parameter int unsigned LIMIT = 16,
  parameter int unsigned CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(LIMIT - 32'd1);

  logic [CNT_W-1:0] cnt_r;

  // Count register: clear wins over enable, holds once terminal is reached.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en && (cnt_r != TERMINAL)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = (cnt_r == TERMINAL);

endmodule

// File: rtl/wb_master_bridge.sv
// Wishbone classic initiator: one CPU load/store becomes one 8-bit bus cycle,
// ended by ACK or by timeout, followed by a one-cycle DONE/ERR response.
module wb_master_bridge
  import wb_master_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  wb_master_bridge_if.master bus
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT);

  state_e                state_r, state_s;
  logic                  rdy_r, rdy_s;
  logic                  done_r, done_s;
  logic                  err_r, err_s;
  logic                  cyc_r, cyc_s;
  logic                  we_r, we_s;
  logic [ADDR_WIDTH-1:0] adr_r, adr_s;
  logic [WB_DW-1:0]      dat_r, dat_s;
  logic [WB_DW-1:0]      rdat_r, rdat_s;
  logic                  accept_s, ack_s, expire_s, cnt_en_s;

  // ACK only counts while a cycle is on the bus, so always-ACK responders are safe.
  assign accept_s = (state_r == IDLE) && bus.CPU_REQ;
  assign ack_s    = (state_r == BUS) && bus.WB_ACKi;
  assign cnt_en_s = (state_r == BUS) && !bus.WB_ACKi;

  wb_timeout_cnt #(
    .LIMIT (TIMEOUT),
    .CNT_W (CNT_W)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept_s),
    .en     (cnt_en_s),
    .expire (expire_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; ACK takes priority over an expiring counter.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.CPU_REQ) state_s = BUS;
        else             state_s = IDLE;
      end
      BUS: begin
        if (bus.WB_ACKi || expire_s) state_s = RESP;
        else                         state_s = BUS;
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    rdy_s  = (state_s == IDLE);
    done_s = ack_s;
    err_s  = (state_r == BUS) && !bus.WB_ACKi && expire_s;
    cyc_s  = (state_s == BUS);
    if (accept_s) begin
      adr_s = bus.CPU_ADDR;
      dat_s = bus.CPU_WDAT;
      we_s  = bus.CPU_WE;
    end else begin
      adr_s = adr_r;
      dat_s = dat_r;
      we_s  = we_r && (state_s == BUS);
    end
    if (ack_s && !we_r) rdat_s = bus.WB_DATi;
    else                rdat_s = rdat_r;
  end

  // Output registers; reset drops CYC/STB asynchronously mid-cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_r  <= 1'b1;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      cyc_r  <= 1'b0;
      we_r   <= 1'b0;
      adr_r  <= {ADDR_WIDTH{1'b0}};
      dat_r  <= {WB_DW{1'b0}};
      rdat_r <= {WB_DW{1'b0}};
    end else begin
      rdy_r  <= rdy_s;
      done_r <= done_s;
      err_r  <= err_s;
      cyc_r  <= cyc_s;
      we_r   <= we_s;
      adr_r  <= adr_s;
      dat_r  <= dat_s;
      rdat_r <= rdat_s;
    end
  end

  assign bus.CPU_RDY  = rdy_r;
  assign bus.CPU_DONE = done_r;
  assign bus.CPU_ERR  = err_r;
  assign bus.CPU_RDAT = rdat_r;
  assign bus.WB_ADRo  = adr_r;
  assign bus.WB_DATo  = dat_r;
  assign bus.WB_WEo   = we_r;
  assign bus.WB_CYCo  = cyc_r;
  assign bus.WB_STBo  = cyc_r;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Self-checking bench for wb_master_bridge: table of single transfers against a
// programmable responder, plus back-to-back and mid-cycle reset sequences.
module tb_wb_master_bridge;

  localparam int unsigned AW = 24;
  localparam int unsigned TO = 16;

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [7:0]    dat;
    logic          err;
    logic [7:0]    rdat;
    int            len;
    int            acc;
  } exp_t;

  // mode: 0 = never ACK, 1 = ACK tied high, 2 = ACK in STB cycle index ack_wait
  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [7:0]    wdat;
    int            mode;
    int            ack_wait;
    logic [7:0]    rd_in;
    logic          exp_err;
    logic [7:0]    exp_rdat;
    int            exp_len;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         bus_starts = 0;
  int         resp_mode = 0;
  int         ack_wait = 0;
  int         stb_cnt = 0;
  logic [7:0] rd_data = 8'h00;
  exp_t       sb[$];
  logic       mon_active = 1'b0;
  int         cur_len = 0;
  logic       rdy_due = 1'b0;

  wb_master_bridge_if #(.ADDR_WIDTH(AW)) bus_if ();

  wb_master_bridge #(
    .ADDR_WIDTH (AW),
    .TIMEOUT    (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Responder: counts STB cycles of the current bus cycle (0 in the first one).
  always @(posedge clk) stb_cnt <= (bus_if.WB_CYCo && bus_if.WB_STBo) ? stb_cnt + 1 : 0;

  assign bus_if.WB_ACKi = (resp_mode == 1) ? 1'b1 :
                          (resp_mode == 2) ? (bus_if.WB_CYCo && (stb_cnt == ack_wait)) : 1'b0;
  assign bus_if.WB_DATi = rd_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive a request at a negedge, wait for RDY, record the expected outcome.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                       input logic e_err, input logic [7:0] e_rdat, input int len,
                       input bit keep, output int acc);
    exp_t e;
    int   g;
    bus_if.CPU_REQ  = 1'b1;
    bus_if.CPU_WE   = we;
    bus_if.CPU_ADDR = a;
    bus_if.CPU_WDAT = d;
    g = 0;
    while (bus_if.CPU_RDY !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("rdy_wait", 32'(g < 100), 32'd1);
    acc    = cyc + 1;
    e.we   = we;
    e.adr  = a;
    e.dat  = d;
    e.err  = e_err;
    e.rdat = e_rdat;
    e.len  = len;
    e.acc  = acc;
    sb.push_back(e);
    @(negedge clk);
    if (!keep) bus_if.CPU_REQ = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("drain", sb.size(), 32'd0);
    sb.delete();
    @(negedge clk);
  endtask

  // Monitor/scoreboard: checks every bus cycle and every DONE/ERR response.
  always @(negedge clk) begin
    if (!rst) begin
      mon_active <= 1'b0;
      cur_len    <= 0;
      rdy_due    <= 1'b0;
    end else begin
      if (rdy_due) check("rdy_after_resp", bus_if.CPU_RDY, 32'd1);
      rdy_due    <= 1'b0;
      mon_active <= bus_if.WB_CYCo;
      if (bus_if.WB_CYCo) begin
        check("stb_with_cyc", bus_if.WB_STBo, 32'd1);
        cur_len <= mon_active ? cur_len + 1 : 1;
        if (!mon_active) bus_starts <= bus_starts + 1;
        if (sb.size() == 0) begin
          check("unexpected_cycle", sb.size(), 32'd1);
        end else begin
          check("wb_adr", bus_if.WB_ADRo, sb[0].adr);
          check("wb_dat", bus_if.WB_DATo, sb[0].dat);
          check("wb_we", bus_if.WB_WEo, sb[0].we);
          if (!mon_active) check("start_latency", cyc, sb[0].acc);
        end
      end
      if (bus_if.CPU_DONE || bus_if.CPU_ERR) begin
        if (sb.size() == 0) begin
          check("spurious_resp", sb.size(), 32'd1);
        end else begin
          check("resp_kind", {bus_if.CPU_DONE, bus_if.CPU_ERR}, {~sb[0].err, sb[0].err});
          check("bus_len", cur_len, sb[0].len);
          check("resp_latency", cyc, sb[0].acc + sb[0].len);
          check("cpu_rdat", bus_if.CPU_RDAT, sb[0].rdat);
          check("rdy_in_resp", bus_if.CPU_RDY, 32'd0);
          check("cyc_stb_dropped", {bus_if.WB_CYCo, bus_if.WB_STBo}, 32'd0);
          if (!sb[0].err) check("we_dropped", bus_if.WB_WEo, 32'd0);
          sb.delete(0);
          rdy_due <= 1'b1;
        end
      end
    end
  end

  initial begin
    vec_t vt[8];
    int   acc_now, acc_prev, starts0;
    acc_prev = 0;

    vt[0] = '{1'b1, 24'h000004, 8'hA5, 1, 0,  8'h00, 1'b0, 8'h00, 1};   // zero-wait write
    vt[1] = '{1'b0, 24'h000001, 8'h00, 2, 2,  8'h3C, 1'b0, 8'h3C, 3};   // 2 wait states read
    vt[2] = '{1'b0, 24'h000002, 8'h00, 0, 0,  8'hFF, 1'b1, 8'h3C, 16};  // timeout, RDAT kept
    vt[3] = '{1'b0, 24'h000003, 8'h00, 2, 15, 8'h5A, 1'b0, 8'h5A, 16};  // ACK on last cycle
    vt[4] = '{1'b1, 24'hABCDEF, 8'h11, 2, 1,  8'h99, 1'b0, 8'h5A, 2};   // write leaves RDAT
    vt[5] = '{1'b0, 24'hFFFFFF, 8'h00, 1, 0,  8'hC3, 1'b0, 8'hC3, 1};   // zero-wait read
    vt[6] = '{1'b1, 24'h000010, 8'h77, 0, 0,  8'h00, 1'b1, 8'hC3, 16};  // write timeout
    vt[7] = '{1'b0, 24'h000123, 8'h00, 2, 14, 8'hE7, 1'b0, 8'hE7, 15};  // one short of timeout

    bus_if.CPU_REQ  = 1'b0;
    bus_if.CPU_WE   = 1'b0;
    bus_if.CPU_ADDR = 24'h000000;
    bus_if.CPU_WDAT = 8'h00;

    @(negedge clk);
    check("rst_rdy", bus_if.CPU_RDY, 32'd1);
    check("rst_done", bus_if.CPU_DONE, 32'd0);
    check("rst_err", bus_if.CPU_ERR, 32'd0);
    check("rst_rdat", bus_if.CPU_RDAT, 32'd0);
    check("rst_cyc", bus_if.WB_CYCo, 32'd0);
    check("rst_stb", bus_if.WB_STBo, 32'd0);
    check("rst_we", bus_if.WB_WEo, 32'd0);
    check("rst_adr", bus_if.WB_ADRo, 32'd0);
    check("rst_dat", bus_if.WB_DATo, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      resp_mode = vt[i].mode;
      ack_wait  = vt[i].ack_wait;
      rd_data   = vt[i].rd_in;
      issue(vt[i].we, vt[i].adr, vt[i].wdat, vt[i].exp_err, vt[i].exp_rdat,
            vt[i].exp_len, 1'b0, acc_now);
      drain();
    end

    // REQ held high across four writes: accepted every third clock, none lost.
    resp_mode = 1;
    starts0   = bus_starts;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 24'(i), 8'h40 + 8'(i), 1'b0, vt[7].exp_rdat, 1, (i < 3), acc_now);
      if (i > 0) check("b2b_spacing", acc_now - acc_prev, 32'd3);
      acc_prev = acc_now;
    end
    drain();
    check("b2b_bus_cycles", bus_starts - starts0, 32'd4);

    // Reset during a wait-stated write drops the bus at once with no response.
    resp_mode = 0;
    issue(1'b1, 24'h000020, 8'h99, 1'b1, vt[7].exp_rdat, 16, 1'b0, acc_now);
    repeat (3) @(negedge clk);
    check("pre_rst_cyc", bus_if.WB_CYCo, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_cyc_stb_we", {bus_if.WB_CYCo, bus_if.WB_STBo, bus_if.WB_WEo}, 32'd0);
    check("async_rst_resp", {bus_if.CPU_DONE, bus_if.CPU_ERR}, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_rdy", bus_if.CPU_RDY, 32'd1);
      check("post_rst_no_resp", {bus_if.CPU_DONE, bus_if.CPU_ERR}, 32'd0);
    end
    check("post_rst_rdat", bus_if.CPU_RDAT, 32'd0);

    resp_mode = 2;
    ack_wait  = 1;
    rd_data   = 8'h6B;
    issue(1'b0, 24'h000055, 8'h00, 1'b0, 8'h6B, 2, 1'b0, acc_now);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
